// File: rtl/key_event_decoder_pkg.sv
// Shared types for the key event decoder: menu commands, repeat FSM states, HID keycodes.
// Latency: n/a (types and a purely combinational decode function).
// Backpressure: n/a.
package key_pkg;

   typedef enum logic [2:0] {
      CMD_UP      = 3'd0,
      CMD_DOWN    = 3'd1,
      CMD_LEFT    = 3'd2,
      CMD_RIGHT   = 3'd3,
      CMD_CONFIRM = 3'd4,
      CMD_BACK    = 3'd5
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT
   } rep_state_t;

   localparam logic [7:0] KC_W     = 8'h1A;
   localparam logic [7:0] KC_S     = 8'h16;
   localparam logic [7:0] KC_A     = 8'h04;
   localparam logic [7:0] KC_D     = 8'h07;
   localparam logic [7:0] KC_ENTER = 8'h28;
   localparam logic [7:0] KC_ESC   = 8'h29;

   typedef struct packed {
      logic vld;
      cmd_t cmd;
   } dec_t;

   // Map a HID keycode onto a menu command; anything unmapped is not a command.
   function automatic dec_t decode_key(input logic [7:0] kc);
      dec_t d;
      d.vld = 1'b1;
      d.cmd = CMD_UP;
      case (kc)
         KC_W:     d.cmd = CMD_UP;
         KC_S:     d.cmd = CMD_DOWN;
         KC_A:     d.cmd = CMD_LEFT;
         KC_D:     d.cmd = CMD_RIGHT;
         KC_ENTER: d.cmd = CMD_CONFIRM;
         KC_ESC:   d.cmd = CMD_BACK;
         default:  d.vld = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Command stream between the key decoder (master) and the game logic (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready; a command transfers on a cycle with cmd_valid && cmd_ready.
interface key_event_decoder_if;
   import key_pkg::*;

   cmd_t cmd;
   logic cmd_valid;
   logic cmd_ready;

   modport master (output cmd, output cmd_valid, input cmd_ready);
   modport slave  (input cmd, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/key_event_decoder_cmd_fifo.sv
// Small synchronous FIFO of menu commands, head presented combinationally (0 when empty).
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: a push while full is accepted only together with a pop; otherwise it is ignored.
module cmd_fifo
   import key_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic push,
   input  cmd_t push_cmd,
   input  logic pop,
   output cmd_t head_cmd,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   cmd_t           mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;
   assign head_cmd = empty ? CMD_UP : mem[rd_ptr[AW-1:0]];

   // Pointer update; extra MSB distinguishes full from empty.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are don't-care until the pointers cover them.
   always_ff @(posedge Clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_cmd;
   end

endmodule

// File: rtl/key_event_decoder.sv
// Debounces the NIOS keycode and turns it into one-shot menu commands with hold-to-repeat.
// Latency: keycode change to command push is STABLE_CYCLES+1 edges; repeats every DELAY then PERIOD.
// Backpressure: commands queue in a FIFO; pushes into a full FIFO are dropped and flag sticky overflow.
module key_event_decoder
   import key_pkg::*;
#(
   parameter int STABLE_CYCLES = 1000,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [7:0]          keycode,
   key_event_decoder_if.master cmd_if,
   output logic                overflow,
   output logic                key_held
);

   localparam int STAB_W  = $clog2(STABLE_CYCLES) + 1;
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX) + 1;

   localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [REP_W-1:0]  DELAY_LOAD  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0]  PERIOD_LOAD = REP_W'(REPEAT_PERIOD - 1);

   logic [7:0]        kc_q;
   logic [7:0]        cand;
   logic [7:0]        stable_code;
   logic [STAB_W-1:0] stab_cnt;
   dec_t              dec;
   rep_state_t        state;
   logic [REP_W-1:0]  rep_cnt;
   cmd_t              last_cmd;
   logic              push_vld;
   cmd_t              push_cmd;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;

   // Sample the PIO and require a run of identical samples before accepting a new code.
   // stab_cnt counts consecutive samples equal to cand, and the sample that reloads cand
   // is already the first of that run, so STABLE_CYCLES samples land on STAB_LAST.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         kc_q        <= 8'h00;
         cand        <= 8'h00;
         stab_cnt    <= '0;
         stable_code <= 8'h00;
      end else begin
         kc_q <= keycode;
         if (kc_q != cand) begin
            cand     <= kc_q;
            stab_cnt <= STAB_W'(1);
         end else if (stab_cnt != STAB_LAST) begin
            stab_cnt <= stab_cnt + 1'b1;
         end else begin
            stable_code <= cand;
         end
      end
   end

   assign dec      = decode_key(stable_code);
   assign push_cmd = dec.cmd;

   // Push on a fresh press, on a change of key, or when the repeat timer expires.
   always_comb begin
      push_vld = 1'b0;
      if (dec.vld) begin
         if (state == ST_IDLE)
            push_vld = 1'b1;
         else if ((dec.cmd != last_cmd) || (rep_cnt == '0))
            push_vld = 1'b1;
      end
   end

   // Repeat FSM: a key change wins over timer expiry and restarts the initial delay.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         rep_cnt  <= '0;
         last_cmd <= CMD_UP;
      end else begin
         case (state)
            ST_IDLE: begin
               if (dec.vld) begin
                  last_cmd <= dec.cmd;
                  rep_cnt  <= DELAY_LOAD;
                  state    <= ST_DELAY;
               end
            end
            default: begin
               if (!dec.vld) begin
                  state <= ST_IDLE;
               end else if (dec.cmd != last_cmd) begin
                  last_cmd <= dec.cmd;
                  rep_cnt  <= DELAY_LOAD;
                  state    <= ST_DELAY;
               end else if (rep_cnt == '0) begin
                  rep_cnt <= PERIOD_LOAD;
                  state   <= ST_REPEAT;
               end else begin
                  rep_cnt <= rep_cnt - 1'b1;
               end
            end
         endcase
      end
   end

   assign cmd_if.cmd_valid = !fifo_empty;
   assign pop              = cmd_if.cmd_valid && cmd_if.cmd_ready;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .push     (push_vld),
      .push_cmd (push_cmd),
      .pop      (pop),
      .head_cmd (cmd_if.cmd),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Registered status: held-key indication and sticky drop flag.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         key_held <= 1'b0;
         overflow <= 1'b0;
      end else begin
         key_held <= dec.vld;
         if (push_vld && fifo_full && !pop) overflow <= 1'b1;
      end
   end

endmodule
